// File: rtl/match_streak_detector.sv
// Counts consecutive X==Y matches on sampled TICKs; after STREAK_LEN matches, holds Z high for HOLD_CYCLES clocks.
// Optional build macro MSD_GRACE_EN forgives one mismatch per streak.
module match_streak_detector #(
  parameter int unsigned STREAK_LEN  = 8,
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned HOLD_CYCLES = 100,
  localparam int unsigned SW         = $clog2(STREAK_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             Z,
  output logic [SW-1:0]    STREAK,
  output logic [7:0]       WINS,
  output logic             GRACE_USED
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WIN  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] streak_n;
  logic [HW-1:0] hold, hold_n;
  logic [7:0]    wins_n;
  logic          z_n;
  logic          grace_n;
  logic          match;

  assign match = (X == Y);

  // State and all outputs are registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      Z          <= 1'b0;
      STREAK     <= '0;
      WINS       <= '0;
      GRACE_USED <= 1'b0;
      hold       <= '0;
    end else begin
      state      <= state_n;
      Z          <= z_n;
      STREAK     <= streak_n;
      WINS       <= wins_n;
      GRACE_USED <= grace_n;
      hold       <= hold_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    z_n      = Z;
    streak_n = STREAK;
    wins_n   = WINS;
    grace_n  = GRACE_USED;
    hold_n   = hold;
    case (state)
      IDLE, RUN: begin
        if (TICK) begin
          if (match) begin
            if (STREAK == SW'(STREAK_LEN - 1)) begin
              state_n  = WIN;
              streak_n = SW'(STREAK_LEN);
              z_n      = 1'b1;
              hold_n   = HW'(HOLD_CYCLES - 1);
              if (WINS != 8'hFF) begin
                wins_n = WINS + 8'd1;
              end
            end else begin
              state_n  = RUN;
              streak_n = STREAK + SW'(1);
            end
          end else begin
`ifdef MSD_GRACE_EN
            // A zero streak has nothing to forgive, so the grace is kept.
            if (STREAK != '0) begin
              if (!GRACE_USED) begin
                grace_n = 1'b1;
              end else begin
                state_n  = IDLE;
                streak_n = '0;
                grace_n  = 1'b0;
              end
            end
`else
            state_n  = IDLE;
            streak_n = '0;
`endif
          end
        end
      end
      WIN: begin
        // hold counts the Z-high cycles still to come after this one.
        if (hold == '0) begin
          state_n  = IDLE;
          z_n      = 1'b0;
          streak_n = '0;
          grace_n  = 1'b0;
        end else begin
          hold_n = hold - HW'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        z_n      = 1'b0;
        streak_n = '0;
        grace_n  = 1'b0;
        hold_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_match_streak_detector.sv
// Directed self-checking bench: instance a (WIDTH=4, STREAK_LEN=8, HOLD=100) and instance b (STREAK_LEN=1, HOLD=1).
module tb_match_streak_detector;

  logic       clk = 1'b0;
  logic       rst_a, tick_a, rst_b, tick_b;
  logic [3:0] x_a, y_a;
  logic       x_b, y_b;
  logic       z_a, z_b, g_a, g_b;
  logic [3:0] streak_a;
  logic       streak_b;
  logic [7:0] wins_a, wins_b;

  int checks = 0;
  int failures = 0;
  int zcount;

  always #5 clk = ~clk;

  match_streak_detector #(.STREAK_LEN(8), .WIDTH(4), .HOLD_CYCLES(100)) dut_a (
    .CLK(clk), .RST(rst_a), .TICK(tick_a), .X(x_a), .Y(y_a),
    .Z(z_a), .STREAK(streak_a), .WINS(wins_a), .GRACE_USED(g_a)
  );

  match_streak_detector #(.STREAK_LEN(1), .WIDTH(1), .HOLD_CYCLES(1)) dut_b (
    .CLK(clk), .RST(rst_b), .TICK(tick_b), .X(x_b), .Y(y_b),
    .Z(z_b), .STREAK(streak_b), .WINS(wins_b), .GRACE_USED(g_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock on instance a with the given inputs, sampled 1 time unit after the edge.
  task automatic cyc_a(input logic r, input logic t, input logic [3:0] x, input logic [3:0] y);
    rst_a = r; tick_a = t; x_a = x; y_a = y;
    @(posedge clk); #1;
    rst_a = 1'b0; tick_a = 1'b0;
  endtask

  task automatic cyc_b(input logic r, input logic t, input logic x, input logic y);
    rst_b = r; tick_b = t; x_b = x; y_b = y;
    @(posedge clk); #1;
    rst_b = 1'b0; tick_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; tick_a = 1'b0; x_a = '0; y_a = '0;
    rst_b = 1'b1; tick_b = 1'b0; x_b = 1'b0; y_b = 1'b0;

    // Reset values
    cyc_a(1'b1, 1'b1, 4'h1, 4'h1);
    check("rst_z", 32'(z_a), 32'd0);
    check("rst_streak", 32'(streak_a), 32'd0);
    check("rst_wins", 32'(wins_a), 32'd0);
    check("rst_grace", 32'(g_a), 32'd0);

    // Eight matching ticks: streak 1..8, win on the eighth
    for (int i = 1; i <= 8; i++) begin
      cyc_a(1'b0, 1'b1, 4'h1, 4'h1);
      check("run_streak", 32'(streak_a), 32'(i));
      check("run_z", 32'(z_a), (i == 8) ? 32'd1 : 32'd0);
    end
    check("win1_wins", 32'(wins_a), 32'd1);

    // Z held 100 cycles; ticks every cycle during WIN (including the last) ignored
    zcount = 1;
    for (int i = 0; i < 99; i++) begin
      cyc_a(1'b0, 1'b1, 4'h5, 4'h5);
      if (z_a) zcount++;
    end
    check("hold_len", 32'(zcount), 32'd100);
    check("hold_streak", 32'(streak_a), 32'd8);
    cyc_a(1'b0, 1'b1, 4'h5, 4'h5);
    check("leave_z", 32'(z_a), 32'd0);
    check("leave_streak", 32'(streak_a), 32'd0);
    check("leave_wins", 32'(wins_a), 32'd1);

    // Mismatch at zero streak: no effect, grace not consumed
    cyc_a(1'b0, 1'b1, 4'hA, 4'hB);
    check("mm0_streak", 32'(streak_a), 32'd0);
    check("mm0_grace", 32'(g_a), 32'd0);

    // Five matches, idle cycles hold the streak
    for (int i = 0; i < 5; i++) cyc_a(1'b0, 1'b1, 4'h7, 4'h7);
    for (int i = 0; i < 3; i++) cyc_a(1'b0, 1'b0, 4'h0, 4'hF);
    check("hold_tick0", 32'(streak_a), 32'd5);

    // One mismatch, then match until the win
    cyc_a(1'b0, 1'b1, 4'h3, 4'hC);
`ifdef MSD_GRACE_EN
    check("mm5_streak", 32'(streak_a), 32'd5);
    check("mm5_grace", 32'(g_a), 32'd1);
    for (int i = 0; i < 2; i++) cyc_a(1'b0, 1'b1, 4'h9, 4'h9);
    check("pre_win2_z", 32'(z_a), 32'd0);
    check("pre_win2_streak", 32'(streak_a), 32'd7);
`else
    check("mm5_streak", 32'(streak_a), 32'd0);
    check("mm5_grace", 32'(g_a), 32'd0);
    for (int i = 0; i < 7; i++) cyc_a(1'b0, 1'b1, 4'h9, 4'h9);
    check("pre_win2_z", 32'(z_a), 32'd0);
    check("pre_win2_streak", 32'(streak_a), 32'd7);
`endif
    cyc_a(1'b0, 1'b1, 4'h9, 4'h9);
    check("win2_z", 32'(z_a), 32'd1);
    check("win2_streak", 32'(streak_a), 32'd8);
    check("win2_wins", 32'(wins_a), 32'd2);
    for (int i = 0; i < 99; i++) cyc_a(1'b0, 1'b0, 4'h0, 4'h0);
    check("win2_last_z", 32'(z_a), 32'd1);
    cyc_a(1'b0, 1'b0, 4'h0, 4'h0);
    check("win2_end_z", 32'(z_a), 32'd0);
    check("win2_end_grace", 32'(g_a), 32'd0);
    check("win2_end_streak", 32'(streak_a), 32'd0);

    // Reset 10 cycles into a win, with a tick on the same edge
    for (int i = 0; i < 8; i++) cyc_a(1'b0, 1'b1, 4'hE, 4'hE);
    check("win3_wins", 32'(wins_a), 32'd3);
    for (int i = 0; i < 10; i++) cyc_a(1'b0, 1'b0, 4'h0, 4'h0);
    cyc_a(1'b1, 1'b1, 4'hE, 4'hE);
    check("midrst_z", 32'(z_a), 32'd0);
    check("midrst_wins", 32'(wins_a), 32'd0);
    check("midrst_streak", 32'(streak_a), 32'd0);
    for (int i = 0; i < 8; i++) cyc_a(1'b0, 1'b1, 4'h2, 4'h2);
    check("postrst_z", 32'(z_a), 32'd1);
    check("postrst_wins", 32'(wins_a), 32'd1);

    // Instance b: single-tick wins, one-cycle hold, saturating win count
    cyc_b(1'b1, 1'b0, 1'b0, 1'b0);
    check("b_rst_wins", 32'(wins_b), 32'd0);
    check("b_rst_z", 32'(z_b), 32'd0);
    for (int i = 1; i <= 256; i++) begin
      cyc_b(1'b0, 1'b1, 1'b1, 1'b1);
      check("b_win_z", 32'(z_b), 32'd1);
      check("b_win_wins", 32'(wins_b), (i > 255) ? 32'd255 : 32'(i));
      // Tick on the only WIN cycle must be discarded
      cyc_b(1'b0, 1'b1, 1'b0, 1'b0);
      check("b_last_z", 32'(z_b), 32'd0);
      check("b_last_streak", 32'(streak_b), 32'd0);
    end
    check("b_sat", 32'(wins_b), 32'd255);
    check("b_grace", 32'(g_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/match_streak_detector.md
# match_streak_detector

Parametrised successor to the precision-button-press sequence FSM. On each sample strobe it compares two WIDTH-bit buses and counts consecutive matches. After STREAK_LEN matches it asserts a registered win output for exactly HOLD_CYCLES clocks, then rearms. It sits between the debounced button/switch sampling logic and the scoring/display logic, and reports the live streak and a saturating win count.

## Interface
- STREAK_LEN, 8: matches required to win; legal range ≥ 1.
- WIDTH, 1: width of compared buses; legal range ≥ 1.
- HOLD_CYCLES, 100: clock cycles Z stays high per win; legal range ≥ 1.
- SW = $clog2(STREAK_LEN+1): derived width of STREAK; not overridden.
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- TICK  in  1  sample strobe; a compare is evaluated only on cycles with TICK=1.
- X  in  WIDTH  player input.
- Y  in  WIDTH  target pattern.
- Z  out  1  win indicator, registered.
- STREAK  out  SW  current consecutive-match count, registered.
- WINS  out  8  number of wins since reset, saturating at 255.
- GRACE_USED  out  1  the current streak has consumed its forgiven mismatch; tied 0 when grace is compiled out.

## Operation
- Reset values: state IDLE, Z=0, STREAK=0, WINS=0, GRACE_USED=0, hold counter 0.
- States: IDLE (STREAK=0), RUN (0<STREAK<STREAK_LEN), WIN.
- IDLE or RUN, TICK=0: all state holds.
- IDLE or RUN, TICK=1, X==Y:
  - STREAK increments.
  - If the new value equals STREAK_LEN, go to WIN; otherwise go to RUN.
- IDLE or RUN, TICK=1, X!=Y: STREAK←0 and go to IDLE. Grace variant: see Configuration.
- On entering WIN:
  - Z←1 and the hold counter loads.
  - WINS increments unless it is already 255.
  - STREAK holds at STREAK_LEN.
- In WIN, TICK, X and Y are ignored. Z stays high for exactly HOLD_CYCLES cycles.
- Leaving WIN: go to IDLE with Z←0, STREAK←0 and GRACE_USED←0.
- STREAK_LEN=1: a single matched tick wins.
- RST asserted in any state, including mid-WIN: the next cycle shows reset values.
- RST has priority over TICK on the same cycle.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Win timing: a matching TICK at edge n, with STREAK=STREAK_LEN−1, gives Z=1 on cycles n+1 … n+HOLD_CYCLES and Z=0 at n+HOLD_CYCLES+1.
- Also at edge n+1: STREAK=STREAK_LEN and WINS has incremented.
- A TICK during any WIN cycle, including the last, is discarded. The first counted TICK after a win is at edge n+HOLD_CYCLES+1 or later.
- STREAK updates on the edge following a sampled TICK.
- Back-to-back TICKs on consecutive cycles are legal and each one counts.

## Configuration
- MSD_GRACE_EN defined:
  - When STREAK>0 and GRACE_USED=0, a mismatching TICK is forgiven: STREAK holds and GRACE_USED←1.
  - A mismatch with GRACE_USED=1 sets STREAK←0, GRACE_USED←0 and goes to IDLE.
  - A mismatch at STREAK=0 has no effect; the grace is not consumed.
  - GRACE_USED clears on reset and on leaving WIN.
- MSD_GRACE_EN undefined: every mismatching TICK resets the streak, and GRACE_USED is constant 0.

## Test plan
- Reset, then 8 consecutive TICKs with X=Y=1 (STREAK_LEN=8, HOLD_CYCLES=100) → STREAK counts 1…8, Z=1 for exactly 100 cycles, WINS=1, then STREAK=0 and Z=0.
- 5 matching TICKs, 1 mismatch, 8 matching TICKs:
  - Grace off: STREAK 5→0, then a win 8 ticks later.
  - Grace on: STREAK holds at 5 with GRACE_USED=1, and the win comes after 3 more matches.
- WIDTH=4, X=4'hA, Y=4'hB on a TICK → STREAK stays 0. TICKs every cycle during WIN → ignored, no second win, WINS=1.
- RST asserted 10 cycles into WIN → Z=0, WINS=0, STREAK=0 next cycle. A subsequent win works normally.
- 256 wins with HOLD_CYCLES=1, STREAK_LEN=1 → WINS saturates at 255, Z pulses one cycle per matched tick, and the tick on the last WIN cycle is ignored.
